microwave_countdown_timer: RTL and testbench
============================================

# microwave_countdown_timer

Countdown core for the microwave controller. Accepts keypad digits, holds the cook time as four BCD digits (MM:SS), and counts down once per 1 Hz tick while cooking. Drives `min_D1`/`min_D0`/`sec_D1`/`sec_D0` directly into `display_7seg_timer`, plus heater and beeper controls.

## Interface

- `BEEP_TICKS`, 3: number of `tick_1hz` pulses that `beep` stays high after the count reaches 00:00 (1–15).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle enable, once per second.
- `key_valid`  in  1  one-cycle strobe: `key_digit` is valid.
- `key_digit`  in  4  keypad digit, BCD.
- `start`  in  1  one-cycle start/resume strobe.
- `stop`  in  1  one-cycle stop/clear strobe.
- `door_open`  in  1  level, door sensor.
- `min_D1`, `min_D0`, `sec_D1`, `sec_D0`  out  4 each  BCD time digits, registered.
- `heater_on`  out  1  high in RUN only.
- `beep`  out  1  high in DONE.
- `done`  out  1  one-cycle pulse on reaching 00:00.

## Operation

- States: IDLE, RUN, PAUSE, DONE.
- Reset: state IDLE; all digits 0; `heater_on`, `beep` and `done` are 0. The beep counter is 0.
- Input priority within one cycle: `stop` > `door_open` > `start` > `tick_1hz` > `key_valid`. Only the highest-priority applicable event acts.
- **IDLE**
  - `key_valid` with `key_digit` ≤ 9 shifts left: `min_D1`←`min_D0`, `min_D0`←`sec_D1`, `sec_D1`←`sec_D0`, `sec_D0`←key. The old `min_D1` is discarded.
  - `key_digit` > 9 is ignored.
  - `start` with time ≠ 00:00 and door closed → RUN. `start` with 00:00 is ignored (see Configuration).
  - `stop` clears all digits to 0.
- **RUN**
  - `tick_1hz` decrements the time.
  - `door_open` → PAUSE, with no decrement in that cycle.
  - `stop` → PAUSE.
  - Keys are ignored.
- **PAUSE**
  - `start` with door closed → RUN.
  - `stop` → IDLE and clears the digits.
  - Ticks and keys are ignored.
- **DONE**
  - Each `tick_1hz` increments the beep counter. When it reaches `BEEP_TICKS`: → IDLE and clear the counter.
  - `stop` → IDLE immediately.
  - `start` and keys are ignored.
- **Decrement** (BCD, MM:SS):
  - If `sec_D0` > 0: `sec_D0`−1.
  - Else if `sec_D1` > 0: `sec_D1`−1 and `sec_D0`=9.
  - Else: seconds become 59 and the minutes decrement in BCD (`min_D0`−1, or `min_D0`=9 and `min_D1`−1).
  - Entered seconds tens of 6–9 are legal (e.g. 01:90) and count down through 01:00 → 00:59.
- **Reaching zero**: the tick edge that writes 00:00 also moves the state to DONE and sets `done` high for exactly one cycle.
- `heater_on` = (state == RUN), registered alongside the state.

## Timing

- All outputs are registered. Every state and digit update is visible on the cycle after the triggering strobe edge.
- Key entry: one digit per `key_valid` strobe. Back-to-back strobes on consecutive cycles are all accepted.
- `start` to `heater_on`: 1 cycle. `door_open` rising to `heater_on` low: 1 cycle.
- `done`: high exactly one cycle, coincident with the first cycle of `beep`.
- `reset` asserted mid-run forces the IDLE/zero state immediately (asynchronous). There is no partial decrement.

## Configuration

- `TIMER_ADD30_EN` defined: quick-add is enabled.
  - `start` in IDLE with 00:00 loads 00:30 and enters RUN.
  - `start` in RUN adds 30 s, with carry into minutes using seconds base 60 when `sec_D1` ≤ 5.
  - If `sec_D1` is 6–9, the 30 s are added to the raw seconds field, with carry past 99.
  - The result saturates at 99:59.
- `TIMER_ADD30_EN` undefined: `start` at 00:00 and `start` in RUN are ignored.

## Test plan

- Reset, then keys 1, 3, 0 → digits 0,1,3,0 (01:30). Key 0xA → no change. Five keys 1,2,3,4,5 → 23:45.
- Load 01:00, `start`, one tick → 00:59, `heater_on`=1. A 2nd tick → 00:58.
- Load 00:02, `start`, 2 ticks → 00:00 and `done` pulses for 1 cycle. `beep` stays high for 3 more ticks, then IDLE with `beep`=0.
- Load 00:10 and RUN. Raise `door_open` with a simultaneous tick → PAUSE, digits still 00:10, `heater_on`=0. `start` while the door is open → ignored. Close the door, `start` → RUN.
- In PAUSE, `stop` → IDLE with 00:00. In RUN, assert `reset` mid-count → all outputs 0 asynchronously.
- With `TIMER_ADD30_EN`: `start` at 00:00 → 00:30 RUN. `start` at 00:45 → 01:15. `start` at 99:50 → 99:59.

Source files
------------

// File: rtl/microwave_countdown_timer.sv
// Microwave countdown core: BCD MM:SS keypad entry, 1 Hz countdown, heater and beeper control.
// Optional quick-add (+30 s on start) is enabled by defining TIMER_ADD30_EN.
module microwave_countdown_timer #(
  parameter int unsigned BEEP_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_open,
  output logic [3:0] min_D1,
  output logic [3:0] min_D0,
  output logic [3:0] sec_D1,
  output logic [3:0] sec_D0,
  output logic       heater_on,
  output logic       beep,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [3:0] BEEP_LAST = 4'(BEEP_TICKS - 1);

  state_t     state;
  logic [3:0] beep_cnt;

  logic       is_zero;
  logic [3:0] dec_m1, dec_m0, dec_s1, dec_s0;
  logic       dec_zero;

  assign is_zero  = ({min_D1, min_D0, sec_D1, sec_D0} == 16'h0000);
  assign dec_zero = ({dec_m1, dec_m0, dec_s1, dec_s0} == 16'h0000);

  // Seconds tens of 6-9 borrow like any other digit, so 01:90 walks down through 01:00.
  always_comb begin : decrement
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dec_m1 = min_D1;
    dec_m0 = min_D0;
    dec_s1 = sec_D1;
    dec_s0 = sec_D0;
    if (sec_D0 != 4'd0) begin
      dec_s0 = sec_D0 - 4'd1;
    end else if (sec_D1 != 4'd0) begin
      dec_s1 = sec_D1 - 4'd1;
      dec_s0 = 4'd9;
    end else begin
      dec_s1 = 4'd5;
      dec_s0 = 4'd9;
      if (min_D0 != 4'd0) begin
        dec_m0 = min_D0 - 4'd1;
      end else begin
        dec_m0 = 4'd9;
        dec_m1 = min_D1 - 4'd1;
      end
    end
  end

`ifdef TIMER_ADD30_EN
  logic [7:0] sec_sum, min_sum;
  logic [3:0] add_m1, add_m0, add_s1, add_s0;

  // Normal seconds carry at 60; an oversized seconds field (6x-9x) carries at 100.
  always_comb begin : add30
    sec_sum = 8'(sec_D1) * 8'd10 + 8'(sec_D0) + 8'd30;
    min_sum = 8'(min_D1) * 8'd10 + 8'(min_D0);
    if (sec_D1 <= 4'd5) begin
      if (sec_sum >= 8'd60) begin
        sec_sum = sec_sum - 8'd60;
        min_sum = min_sum + 8'd1;
      end
    end else if (sec_sum >= 8'd100) begin
      sec_sum = sec_sum - 8'd100;
      min_sum = min_sum + 8'd1;
    end
    if (min_sum > 8'd99) begin
      add_m1 = 4'd9;
      add_m0 = 4'd9;
      add_s1 = 4'd5;
      add_s0 = 4'd9;
    end else begin
      add_m1 = 4'(min_sum / 8'd10);
      add_m0 = 4'(min_sum % 8'd10);
      add_s1 = 4'(sec_sum / 8'd10);
      add_s0 = 4'(sec_sum % 8'd10);
    end
  end
`endif

  // Each state walks its own priority chain; events with no meaning in a state fall through.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      min_D1    <= 4'd0;
      min_D0    <= 4'd0;
      sec_D1    <= 4'd0;
      sec_D0    <= 4'd0;
      heater_on <= 1'b0;
      beep      <= 1'b0;
      done      <= 1'b0;
      beep_cnt  <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (stop) begin
            min_D1 <= 4'd0;
            min_D0 <= 4'd0;
            sec_D1 <= 4'd0;
            sec_D0 <= 4'd0;
          end else if (start && !door_open && !is_zero) begin
            state     <= RUN;
            heater_on <= 1'b1;
`ifdef TIMER_ADD30_EN
          end else if (start && !door_open) begin
            sec_D1    <= 4'd3;
            state     <= RUN;
            heater_on <= 1'b1;
`endif
          end else if (key_valid && key_digit <= 4'd9) begin
            min_D1 <= min_D0;
            min_D0 <= sec_D1;
            sec_D1 <= sec_D0;
            sec_D0 <= key_digit;
          end
        end

        RUN: begin
          if (stop || door_open) begin
            state     <= PAUSE;
            heater_on <= 1'b0;
`ifdef TIMER_ADD30_EN
          end else if (start) begin
            min_D1 <= add_m1;
            min_D0 <= add_m0;
            sec_D1 <= add_s1;
            sec_D0 <= add_s0;
`endif
          end else if (tick_1hz) begin
            min_D1 <= dec_m1;
            min_D0 <= dec_m0;
            sec_D1 <= dec_s1;
            sec_D0 <= dec_s0;
            if (dec_zero) begin
              state     <= DONE;
              heater_on <= 1'b0;
              beep      <= 1'b1;
              done      <= 1'b1;
              beep_cnt  <= 4'd0;
            end
          end
        end

        PAUSE: begin
          if (stop) begin
            state  <= IDLE;
            min_D1 <= 4'd0;
            min_D0 <= 4'd0;
            sec_D1 <= 4'd0;
            sec_D0 <= 4'd0;
          end else if (start && !door_open) begin
            state     <= RUN;
            heater_on <= 1'b1;
          end
        end

        DONE: begin
          if (stop) begin
            state    <= IDLE;
            beep     <= 1'b0;
            beep_cnt <= 4'd0;
          end else if (tick_1hz) begin
            if (beep_cnt == BEEP_LAST) begin
              state    <= IDLE;
              beep     <= 1'b0;
              beep_cnt <= 4'd0;
            end else begin
              beep_cnt <= beep_cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_countdown_timer.sv
// Directed bench for microwave_countdown_timer; define TIMER_ADD30_EN to also exercise quick-add.
module tb_microwave_countdown_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz, key_valid, start, stop, door_open;
  logic [3:0] key_digit;
  logic [3:0] min_D1, min_D0, sec_D1, sec_D0;
  logic       heater_on, beep, done;

  int tests = 0;
  int fails = 0;

  wire [15:0] digits = {min_D1, min_D0, sec_D1, sec_D0};

  microwave_countdown_timer #(.BEEP_TICKS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_1hz  (tick_1hz),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .start     (start),
    .stop      (stop),
    .door_open (door_open),
    .min_D1    (min_D1),
    .min_D0    (min_D0),
    .sec_D1    (sec_D1),
    .sec_D0    (sec_D0),
    .heater_on (heater_on),
    .beep      (beep),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  // Clears from IDLE and enters four digits.
  task automatic load(input logic [15:0] t);
    pulse_stop();
    press_key(t[15:12]);
    press_key(t[11:8]);
    press_key(t[7:4]);
    press_key(t[3:0]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    tests++;
    if (digits !== 16'h0000) begin
      fails++;
      $display("FAIL reset_digits: got %h want 0000", digits);
    end
    tests++;
    if ({heater_on, beep, done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags: got heater/beep/done=%b want 000", {heater_on, beep, done});
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_key_entry();
    press_key(4'd1);
    press_key(4'd3);
    press_key(4'd0);
    tests++;
    if (digits !== 16'h0130) begin
      fails++;
      $display("FAIL keys_130: got %h want 0130", digits);
    end
    press_key(4'hA);
    tests++;
    if (digits !== 16'h0130) begin
      fails++;
      $display("FAIL key_invalid: got %h want 0130", digits);
    end
    pulse_stop();
    for (int i = 1; i <= 5; i++) press_key(4'(i));
    tests++;
    if (digits !== 16'h2345) begin
      fails++;
      $display("FAIL keys_shift_out: got %h want 2345", digits);
    end
    pulse_stop();
    tests++;
    if (digits !== 16'h0000) begin
      fails++;
      $display("FAIL idle_stop_clear: got %h want 0000", digits);
    end
  endtask

  task automatic test_start_at_zero();
    pulse_start();
`ifdef TIMER_ADD30_EN
    tests++;
    if ({digits, heater_on} !== {16'h0030, 1'b1}) begin
      fails++;
      $display("FAIL start_zero_add30: got %h heater=%b want 0030 heater=1", digits, heater_on);
    end
    pulse_stop();
    pulse_stop();
`else
    tests++;
    if ({digits, heater_on} !== {16'h0000, 1'b0}) begin
      fails++;
      $display("FAIL start_zero_ignored: got %h heater=%b want 0000 heater=0", digits, heater_on);
    end
`endif
  endtask

  task automatic test_countdown();
    load(16'h0100);
    pulse_start();
    tests++;
    if ({digits, heater_on} !== {16'h0100, 1'b1}) begin
      fails++;
      $display("FAIL run_start: got %h heater=%b want 0100 heater=1", digits, heater_on);
    end
    pulse_tick();
    tests++;
    if ({digits, heater_on} !== {16'h0059, 1'b1}) begin
      fails++;
      $display("FAIL tick_borrow_min: got %h heater=%b want 0059 heater=1", digits, heater_on);
    end
    pulse_tick();
    tests++;
    if (digits !== 16'h0058) begin
      fails++;
      $display("FAIL tick_second: got %h want 0058", digits);
    end
    pulse_stop();
    tests++;
    if ({digits, heater_on} !== {16'h0058, 1'b0}) begin
      fails++;
      $display("FAIL run_stop_pause: got %h heater=%b want 0058 heater=0", digits, heater_on);
    end
    pulse_tick();
    tests++;
    if (digits !== 16'h0058) begin
      fails++;
      $display("FAIL pause_tick_ignored: got %h want 0058", digits);
    end
    pulse_stop();
    tests++;
    if ({digits, heater_on} !== {16'h0000, 1'b0}) begin
      fails++;
      $display("FAIL pause_stop_idle: got %h heater=%b want 0000 heater=0", digits, heater_on);
    end
  endtask

  task automatic test_done_beep();
    load(16'h0002);
    pulse_start();
    pulse_tick();
    tests++;
    if ({digits, done, beep} !== {16'h0001, 2'b00}) begin
      fails++;
      $display("FAIL pre_zero: got %h done=%b beep=%b want 0001 0 0", digits, done, beep);
    end
    pulse_tick();
    tests++;
    if ({digits, done, beep, heater_on} !== {16'h0000, 3'b110}) begin
      fails++;
      $display("FAIL reach_zero: got %h done=%b beep=%b heater=%b want 0000 1 1 0",
               digits, done, beep, heater_on);
    end
    step();
    tests++;
    if ({done, beep} !== 2'b01) begin
      fails++;
      $display("FAIL done_one_cycle: got done=%b beep=%b want 0 1", done, beep);
    end
    for (int i = 1; i <= 3; i++) begin
      pulse_tick();
      tests++;
      if (beep !== (i < 3)) begin
        fails++;
        $display("FAIL beep_tick%0d: got beep=%b want %b", i, beep, (i < 3));
      end
    end
    press_key(4'd5);
    tests++;
    if (digits !== 16'h0005) begin
      fails++;
      $display("FAIL done_back_idle: got %h want 0005", digits);
    end
  endtask

  task automatic test_door();
    load(16'h0010);
    pulse_start();
    door_open = 1'b1;
    pulse_tick();
    tests++;
    if ({digits, heater_on} !== {16'h0010, 1'b0}) begin
      fails++;
      $display("FAIL door_pause: got %h heater=%b want 0010 heater=0", digits, heater_on);
    end
    pulse_start();
    tests++;
    if (heater_on !== 1'b0) begin
      fails++;
      $display("FAIL start_door_open: got heater=%b want 0", heater_on);
    end
    door_open = 1'b0;
    pulse_start();
    tests++;
    if (heater_on !== 1'b1) begin
      fails++;
      $display("FAIL resume: got heater=%b want 1", heater_on);
    end
    pulse_tick();
    tests++;
    if (digits !== 16'h0009) begin
      fails++;
      $display("FAIL resume_tick: got %h want 0009", digits);
    end
    pulse_stop();
    pulse_stop();
  endtask

  task automatic test_boundaries();
    load(16'h0190);
    pulse_start();
    for (int i = 0; i < 90; i++) pulse_tick();
    tests++;
    if (digits !== 16'h0100) begin
      fails++;
      $display("FAIL wide_sec_down: got %h want 0100", digits);
    end
    pulse_tick();
    tests++;
    if (digits !== 16'h0059) begin
      fails++;
      $display("FAIL wide_sec_borrow: got %h want 0059", digits);
    end
    pulse_stop();
    pulse_stop();
    load(16'h1000);
    pulse_start();
    pulse_tick();
    tests++;
    if (digits !== 16'h0959) begin
      fails++;
      $display("FAIL min_tens_borrow: got %h want 0959", digits);
    end
    pulse_stop();
    pulse_stop();
  endtask

  task automatic test_reset_midrun();
    load(16'h0030);
    pulse_start();
    pulse_tick();
    reset = 1'b1;
    #1;
    tests++;
    if ({digits, heater_on, beep, done} !== {16'h0000, 3'b000}) begin
      fails++;
      $display("FAIL async_reset: got %h heater=%b beep=%b done=%b want all 0",
               digits, heater_on, beep, done);
    end
    step();
    reset = 1'b0;
    press_key(4'd7);
    tests++;
    if ({digits, heater_on} !== {16'h0007, 1'b0}) begin
      fails++;
      $display("FAIL post_reset_idle: got %h heater=%b want 0007 heater=0", digits, heater_on);
    end
  endtask

`ifdef TIMER_ADD30_EN
  task automatic test_add30();
    load(16'h0045);
    pulse_start();
    pulse_start();
    tests++;
    if (digits !== 16'h0115) begin
      fails++;
      $display("FAIL add30_carry: got %h want 0115", digits);
    end
    pulse_stop();
    pulse_stop();
    load(16'h9950);
    pulse_start();
    pulse_start();
    tests++;
    if (digits !== 16'h9959) begin
      fails++;
      $display("FAIL add30_saturate: got %h want 9959", digits);
    end
    pulse_stop();
    pulse_stop();
  endtask
`endif

  initial begin
    reset     = 1'b0;
    tick_1hz  = 1'b0;
    key_valid = 1'b0;
    key_digit = 4'd0;
    start     = 1'b0;
    stop      = 1'b0;
    door_open = 1'b0;
    test_reset();
    test_key_entry();
    test_start_at_zero();
    test_countdown();
    test_done_beep();
    test_door();
    test_boundaries();
    test_reset_midrun();
`ifdef TIMER_ADD30_EN
    test_add30();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
